// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: header, FWFT payload bytes, then even-XOR parity.
// Honours busy back-pressure and inserts IPG idle cycles after every packet.
module router_pkt_tx #(
    parameter int unsigned IPG = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic [6:0] pay_count,
    input  logic [7:0] pay_data,
    output logic       pay_rd,
    input  logic       busy,
    input  logic       err_inject,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StParity,
        StGap
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [5:0] remaining;
    logic [3:0] gap_cnt;
    logic       err_lat;

    // Pop only on an edge where the current header/payload byte is consumed and more remain.
    assign pay_rd = resetn && !busy && (remaining != 6'd0) &&
                    ((state == StHeader) || (state == StPayload));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= StIdle;
            acc       <= 8'h00;
            remaining <= 6'd0;
            gap_cnt   <= 4'd0;
            err_lat   <= 1'b0;
            data_out  <= 8'h00;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start && ({1'b0, pay_len} <= pay_count)) begin
                        data_out  <= {pay_len, dest_addr};
                        acc       <= {pay_len, dest_addr};
                        remaining <= pay_len;
                        err_lat   <= err_inject;
                        pkt_valid <= 1'b1;
                        tx_active <= 1'b1;
                        state     <= StHeader;
                    end
                end
                StHeader, StPayload: begin
                    if (!busy) begin
                        if (remaining != 6'd0) begin
                            data_out  <= pay_data;
                            acc       <= acc ^ pay_data;
                            remaining <= remaining - 6'd1;
                            state     <= StPayload;
                        end else begin
                            data_out  <= acc ^ {7'b0, err_lat};
                            pkt_valid <= 1'b0;
                            state     <= StParity;
                        end
                    end
                end
                StParity: begin
                    if (!busy) begin
                        data_out <= 8'h00;
                        done     <= 1'b1;
                        gap_cnt  <= 4'(IPG);
                        state    <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt <= 4'd1) begin
                        tx_active <= 1'b0;
                        state     <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
